// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with std (registered) or first-word-fall-through read port,
// programmable threshold flags and one-cycle overflow/underflow pulses.
module sync_fifo_param #(
  parameter int    WIDTH             = 8,
  parameter int    DEPTH             = 4096,
  parameter string READ_MODE         = "std",
  parameter int    PROG_FULL_THRESH  = DEPTH - 16,
  parameter int    PROG_EMPTY_THRESH = 16,
  localparam int   AW                = $clog2(DEPTH),
  localparam int   CW                = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             prog_full,
  output logic             prog_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    data_count
);

  localparam bit FWFT = (READ_MODE == "fwft");

  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be 1..256");
  end
  if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 16");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1) begin : g_bad_pf
    $error("sync_fifo_param: PROG_FULL_THRESH out of range");
  end
  if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pe
    $error("sync_fifo_param: PROG_EMPTY_THRESH out of range");
  end
  if (READ_MODE != "std" && READ_MODE != "fwft") begin : g_bad_mode
    $error("sync_fifo_param: READ_MODE must be \"std\" or \"fwft\"");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             run, wr_ok, rd_ok;

  // Single-flop release: ports stay gated for the first edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign wr_ok      = run & wr_en & ~full;
  assign rd_ok      = run & rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + AW'(wr_ok);
  assign rd_ptr_nxt = rd_ptr + AW'(rd_ok);
  assign count_nxt  = data_count + CW'(wr_ok) - CW'(rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      valid      <= 1'b0;
      dout       <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      data_count <= count_nxt;
      full       <= (count_nxt == CW'(DEPTH));
      empty      <= (count_nxt == '0);
      prog_full  <= (count_nxt >= CW'(PROG_FULL_THRESH));
      prog_empty <= (count_nxt <= CW'(PROG_EMPTY_THRESH));
      overflow   <= run & wr_en & full;
      underflow  <= run & rd_en & empty;
      if (FWFT) begin
        // Prefetch the next head; bypass din when it becomes the head this edge.
        if (count_nxt == '0) begin
          valid <= 1'b0;
        end else begin
          valid <= 1'b1;
          if (data_count == '0 || (rd_ok && data_count == CW'(1)))
            dout <= din;
          else
            dout <= mem[rd_ptr_nxt];
        end
      end else begin
        valid <= rd_ok;
        if (rd_ok) dout <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Random + directed bench: std and fwft instances share stimulus and are
// scored against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0;

  logic [7:0] s_dout, f_dout;
  logic       s_valid, s_full, s_empty, s_pf, s_pe, s_ov, s_un;
  logic       f_valid, f_full, f_empty, f_pf, f_pe, f_ov, f_un;
  logic [4:0] s_cnt, f_cnt;

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .READ_MODE("std"),
                    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
    .prog_full(s_pf), .prog_empty(s_pe), .overflow(s_ov), .underflow(s_un),
    .data_count(s_cnt));

  sync_fifo_param #(.WIDTH(8), .DEPTH(D), .READ_MODE("fwft"),
                    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) u_fw (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .prog_full(f_pf), .prog_empty(f_pe), .overflow(f_ov), .underflow(f_un),
    .data_count(f_cnt));

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] q[$];        // reference FIFO contents
  logic [7:0] std_exp[$];  // std read data owed by the DUT
  logic [7:0] s_last = '0;
  bit         mrun = 0, exp_ov = 0, exp_un = 0, exp_sv = 0, done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string p, input logic [4:0] cnt, input logic fu, em,
                           pf, pe, ov, un);
    int n;
    n = q.size();
    chk({p, "count"}, 32'(cnt), 32'(n));
    chk({p, "full"}, 32'(fu), 32'(n == D));
    chk({p, "empty"}, 32'(em), 32'(n == 0));
    chk({p, "prog_full"}, 32'(pf), 32'(n >= 12));
    chk({p, "prog_empty"}, 32'(pe), 32'(n <= 2));
    chk({p, "overflow"}, 32'(ov), 32'(exp_ov));
    chk({p, "underflow"}, 32'(un), 32'(exp_un));
  endtask

  // One clock of stimulus; the reference model advances at the same edge.
  task automatic cycle(input bit w, input bit r, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    wa     = mrun && w && q.size() < D;
    ra     = mrun && r && q.size() > 0;
    exp_ov = mrun && w && q.size() == D;
    exp_un = mrun && r && q.size() == 0;
    exp_sv = ra;
    if (ra) std_exp.push_back(q.pop_front());
    if (wa) q.push_back(d);
    mrun = rst_n;
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) cycle(1'b1, 1'b0, 8'($urandom));
  endtask

  task automatic drain_to(input int n);
    while (q.size() > n) cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    q.delete(); std_exp.delete();
    mrun = 0; exp_ov = 0; exp_un = 0; exp_sv = 0; s_last = '0;
    #1;
    chk("rst_s_dout", 32'(s_dout), 32'h0);
    chk("rst_f_dout", 32'(f_dout), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_f_valid", 32'(f_valid), 32'h0);
    chk_flags("rst_s_", s_cnt, s_full, s_empty, s_pf, s_pe, s_ov, s_un);
    chk_flags("rst_f_", f_cnt, f_full, f_empty, f_pf, f_pe, f_ov, f_un);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    // Write held high across the first edge after release: must be ignored.
    wr_en = 1'b1; din = 8'h77;
    @(posedge clk);
    exp_ov = 0; exp_un = 0; exp_sv = 0;
    mrun = 1;
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        chk_flags("s_", s_cnt, s_full, s_empty, s_pf, s_pe, s_ov, s_un);
        chk_flags("f_", f_cnt, f_full, f_empty, f_pf, f_pe, f_ov, f_un);
        chk("s_valid", 32'(s_valid), 32'(exp_sv));
        if (s_valid && std_exp.size() > 0) s_last = std_exp.pop_front();
        chk("s_dout", 32'(s_dout), 32'(s_last));
        chk("f_valid", 32'(f_valid), 32'(q.size() != 0));
        if (f_valid && q.size() > 0) chk("f_dout", 32'(f_dout), 32'(q[0]));
      end
    end
  end

  initial begin
    do_reset();

    // Fill 0x01..0x10, then read them all back
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Single word fall-through
    cycle(1'b1, 1'b0, 8'hA5);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Simultaneous read/write at full and at empty
    fill_to(D);
    cycle(1'b1, 1'b1, 8'hEE);
    drain_to(0);
    cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Threshold crossings one word at a time
    fill_to(13);
    drain_to(1);

    // Steady streaming at count 8 across many pointer wraps
    fill_to(8);
    repeat (100) cycle(1'b1, 1'b1, 8'($urandom));

    // Random traffic with shifting bias
    for (int seg = 0; seg < 3; seg++) begin
      int wb, rb;
      wb = (seg == 0) ? 75 : (seg == 1) ? 30 : 55;
      rb = (seg == 0) ? 30 : (seg == 1) ? 75 : 50;
      repeat (200)
        cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, 8'($urandom));
    end

    // Reset mid-operation discards contents
    drain_to(0);
    fill_to(10);
    do_reset();
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    @(negedge clk);
    done = 1;
    #1;
    chk("std_reads_outstanding", 32'(std_exp.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..256).
REQ-002 Parameter DEPTH, default 4096, storage words; power of two, >= 16.
REQ-003 Parameter READ_MODE, default "std", either "std" (registered read) or "fwft" (first-word fall-through).
REQ-004 Parameter PROG_FULL_THRESH, default DEPTH-16, prog_full threshold; legal range 1..DEPTH-1.
REQ-005 Parameter PROG_EMPTY_THRESH, default 16, prog_empty threshold; legal range 1..DEPTH-1.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 din  input  WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request (std) or pop/acknowledge of dout (fwft).
REQ-012 dout  output  WIDTH  read data.
REQ-013 valid  output  1  dout holds valid read data.
REQ-014 full / empty  output  1 each  storage full / no readable word.
REQ-015 prog_full / prog_empty  output  1 each  programmable threshold flags.
REQ-016 overflow / underflow  output  1 each  one-cycle rejected-write / rejected-read pulses.
REQ-017 data_count  output  $clog2(DEPTH)+1  words written and not yet read.

Function
REQ-018 Write accepted when wr_en=1 and full=0; din stored at write pointer, pointer advances, wraps DEPTH-1 -> 0.
REQ-019 Read accepted when rd_en=1 and empty=0; read pointer advances, wraps DEPTH-1 -> 0.
REQ-020 std: accepted read drives dout with head word on the next edge; valid=1 that cycle only; dout holds value otherwise.
REQ-021 fwft: when empty=0, dout shows head word and valid=1; accepted read presents the next word (or empty=1, valid=0) on the next edge.
REQ-022 Both modes: empty deasserts on the edge after the write into an empty FIFO; full asserts on the edge when data_count reaches DEPTH.
REQ-023 data_count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write; never exceeds DEPTH or drops below 0.
REQ-024 Simultaneous wr_en and rd_en when full: read accepted, write rejected, overflow=1; data_count goes DEPTH -> DEPTH-1.
REQ-025 Simultaneous wr_en and rd_en when empty: write accepted, read rejected, underflow=1; data_count goes 0 -> 1.
REQ-026 wr_en=1 while full -> write ignored, memory and pointers unchanged, overflow=1 for one cycle.
REQ-027 rd_en=1 while empty -> read ignored, dout unchanged, underflow=1 for one cycle.
REQ-028 prog_full registered = (next data_count >= PROG_FULL_THRESH); prog_empty registered = (next data_count <= PROG_EMPTY_THRESH); both update same edge as data_count.
REQ-029 Every word read out equals the word written, in write order, across any number of pointer wraps.
REQ-030 Illegal parameters (non-power-of-two DEPTH, thresholds out of range, unknown READ_MODE) stop elaboration with an error.

Reset
REQ-031 rst_n=0 immediately forces: pointers 0, data_count 0, empty=1, full=0, prog_empty=1, prog_full=0, valid=0, overflow=0, underflow=0, dout=0.
REQ-032 Reset mid-operation discards all stored words; memory contents need not be cleared.
REQ-033 Reset deassertion is synchronised internally; first write accepted on the second rising clk edge after rst_n rises.

Verification (WIDTH=8, DEPTH=16, PROG_FULL_THRESH=12, PROG_EMPTY_THRESH=2)
REQ-034 std: write 0x01..0x10 -> full=1, data_count=16, prog_full asserted at count 12; read 16 -> dout 0x01..0x10 each 1 cycle after rd_en, empty=1 at end.
REQ-035 fwft: write 0xA5 into empty FIFO -> next cycle dout=0xA5, valid=1, empty=0; rd_en pulse -> empty=1, valid=0, data_count=0.
REQ-036 Full with wr_en=rd_en=1, din=0xEE -> overflow=1, data_count=15, 0xEE never read; empty with wr_en=rd_en=1, din=0x3C -> underflow=1, data_count=1, 0x3C read next.
REQ-037 Continuous simultaneous read/write for 100 cycles at data_count=8 -> count stays 8, ordered data matches across 6+ pointer wraps.
REQ-038 rst_n pulsed low with data_count=10 -> all outputs at reset values at once; subsequent write/read of 0x5A returns 0x5A only.
REQ-039 Threshold edges: counts 2->3 deassert prog_empty, 3->2 reassert; 11->12 assert prog_full, 12->11 deassert, each on the same edge as the count change.
